// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants for the mux select sequencer and the seven-segment display blocks.
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MAN  = 2'b00,
        MODE_AUTO = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp kept dark
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;

    function automatic logic [7:0] seg_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return SEG_0;
            2'd1:    return SEG_1;
            2'd2:    return SEG_2;
            default: return SEG_3;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-FF synchronizer, stability debouncer, registered rising-edge pulse.
module btn_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic            s1, s2;
    logic            level, level_d;
    logic [DB_W-1:0] cnt;

    // cnt measures how long the synced input has disagreed with the accepted level;
    // any return to the accepted level restarts the measurement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            level_d <= level;
            press   <= level & ~level_d;
            if (s2 == level) begin
                cnt <= '0;
            end else if (&cnt) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for the 4-to-1 2-bit switch mux: manual/auto/step/hold select,
// registered LED field, change pulse and seven-segment index digit.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DIV_W = 24,
    parameter int DB_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [1:0] man_sel,
    input  logic [7:0] data_in,
    input  logic       btn_step,
    input  logic       btn_clr,
    output logic [1:0] sel,
    output logic [1:0] light,
    output logic       sel_chg,
    output logic [7:0] seg_out
);

    logic             step_p, clr_p;
    logic [DIV_W-1:0] pre;
    logic             tick;
    logic [1:0]       sel_nxt, sel_prev;
    mode_e            mode_q;

    assign mode_q = mode_e'(mode);

    btn_debounce #(.DB_W(DB_W)) u_db_step (.clk(clk), .rst(rst), .btn(btn_step), .press(step_p));
    btn_debounce #(.DB_W(DB_W)) u_db_clr  (.clk(clk), .rst(rst), .btn(btn_clr),  .press(clr_p));

    assign tick = (mode_q == MODE_AUTO) && (&pre);

    // Held at zero outside auto so every entry into auto starts a full interval
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            pre <= '0;
        else if (clr_p || mode_q != MODE_AUTO) pre <= '0;
        else                                 pre <= pre + DIV_W'(1);
    end

    always_comb begin
        sel_nxt = sel;
        if (clr_p) begin
            sel_nxt = 2'd0;
        end else begin
            case (mode_q)
                MODE_MAN:  sel_nxt = man_sel;
                MODE_AUTO: if (tick)   sel_nxt = sel + 2'd1;
                MODE_STEP: if (step_p) sel_nxt = sel + 2'd1;
                default:   sel_nxt = sel;
            endcase
        end
    end

    // Outputs trail sel by one cycle; sel_chg compares against the previous sel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel      <= 2'd0;
            sel_prev <= 2'd0;
            light    <= 2'd0;
            sel_chg  <= 1'b0;
            seg_out  <= SEG_0;
        end else begin
            sel      <= sel_nxt;
            sel_prev <= sel;
            light    <= data_in[{sel, 1'b0} +: 2];
            sel_chg  <= (sel != sel_prev);
            seg_out  <= seg_code(sel);
        end
    end

endmodule
